// File: rtl/fir4_mac_if.sv
// fir4_mac_if: bundles the signals between the 4-tap FIR MAC stage, its
// controller and the upstream sample shift register.
//   start          request one filter computation
//   coef_flat      four packed signed coefficients, tap k at [k*COEF_WIDTH +: COEF_WIDTH]
//   fifo_r_data    signed tap value read combinationally from the shift register
//   fifo_r_address tap select driven by the MAC
//   busy           MAC is accumulating
//   y / y_valid    filtered result and its one-cycle update strobe
// The slave modport is the MAC itself; the master modport is its environment.
interface fir4_mac_if #(
  parameter int DATA_WIDTH = 12,
  parameter int COEF_WIDTH = 8
);
  localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + 2;

  logic                    start;
  logic [4*COEF_WIDTH-1:0] coef_flat;
  logic [DATA_WIDTH-1:0]   fifo_r_data;
  logic [1:0]              fifo_r_address;
  logic                    busy;
  logic [ACC_WIDTH-1:0]    y;
  logic                    y_valid;

  modport master (
    output start, coef_flat, fifo_r_data,
    input  fifo_r_address, busy, y, y_valid
  );

  modport slave (
    input  start, coef_flat, fifo_r_data,
    output fifo_r_address, busy, y, y_valid
  );
endinterface

// File: rtl/fir4_mac.sv
// fir4_mac: sequential 4-tap FIR multiply-accumulate stage with one multiplier.
// A start in IDLE latches the coefficients, then taps 0..3 are read over four
// ACC cycles and the result is published on y with a one-cycle y_valid pulse.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fir4_mac_if.slave (start, coef_flat, fifo_r_data in;
//          fifo_r_address, busy, y, y_valid out). Interface widths must
//          match DATA_WIDTH / COEF_WIDTH here.
// Build option: define FIR4_SAT_EN to saturate y to the signed DATA_WIDTH
// range (sign-extended to ACC_WIDTH); the accumulator stays full precision.
//
// state | meaning
// IDLE  | waiting for start; address 0, busy low
// ACC   | one tap per cycle, cnt = tap being read
module fir4_mac #(
  parameter int DATA_WIDTH = 12,
  parameter int COEF_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fir4_mac_if.slave    bus
);
  localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + 2;
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

  typedef enum logic {IDLE, ACC} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  y_q, y_d;
  logic                         y_valid_q, y_valid_d;
  logic signed [COEF_WIDTH-1:0] coef_q [4];
  logic signed [COEF_WIDTH-1:0] coef_d [4];

  logic signed [PROD_WIDTH-1:0] data_ext, coef_ext, prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, sum, y_next;

`ifdef FIR4_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  // Operands are widened to the full product width first so the multiply
  // is a plain same-width signed product with no implicit extension.
  always_comb begin
    data_ext = {{COEF_WIDTH{bus.fifo_r_data[DATA_WIDTH-1]}}, bus.fifo_r_data};
    coef_ext = {{DATA_WIDTH{coef_q[cnt_q][COEF_WIDTH-1]}}, coef_q[cnt_q]};
    prod     = data_ext * coef_ext;
    prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    sum      = acc_q + prod_ext;
`ifdef FIR4_SAT_EN
    if (sum > SAT_MAX) begin
      y_next = SAT_MAX;
    end else if (sum < SAT_MIN) begin
      y_next = SAT_MIN;
    end else begin
      y_next = sum;
    end
`else
    y_next = sum;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    coef_d    = coef_q;
    if (state_q == IDLE) begin
      if (bus.start) begin
        for (int k = 0; k < 4; k++) begin
          coef_d[k] = bus.coef_flat[k*COEF_WIDTH +: COEF_WIDTH];
        end
        acc_d   = '0;
        cnt_d   = 2'd0;
        state_d = ACC;
      end
    end else begin
      if (cnt_q == 2'd3) begin
        y_d       = y_next;
        y_valid_d = 1'b1;
        acc_d     = '0;
        cnt_d     = 2'd0;
        state_d   = IDLE;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        coef_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      coef_q    <= coef_d;
    end
  end

  // cnt is cleared whenever ACC is left, so it reads 0 throughout IDLE.
  assign bus.fifo_r_address = cnt_q;
  assign bus.busy           = (state_q == ACC);
  assign bus.y              = y_q;
  assign bus.y_valid        = y_valid_q;
endmodule

// File: tb/tb_fir4_mac.sv
// tb_fir4_mac: directed bench for fir4_mac. Stimulus pushes the expected y
// into a queue; a negedge monitor pops and compares on every y_valid.
// The shift register is modelled as a 4-entry tap array read by address.
module tb_fir4_mac;
  localparam int DW = 12;
  localparam int CW = 8;
  localparam int AW = DW + CW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir4_mac_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW)) bus();

  fir4_mac #(.DATA_WIDTH(DW), .COEF_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic signed [DW-1:0] taps [4];
  assign bus.fifo_r_data = taps[bus.fifo_r_address];

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int cyc = 0;
  int valid_cyc [$];
  logic signed [AW-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.y_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_y_valid: got y=%0d, required no result", $signed(bus.y));
      end else begin
        check("y", longint'($signed(bus.y)), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_taps(input int t0, input int t1, input int t2, input int t3);
    taps[0] = DW'(t0);
    taps[1] = DW'(t1);
    taps[2] = DW'(t2);
    taps[3] = DW'(t3);
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    bus.coef_flat = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endtask

  task automatic wait_valids(input int target, input int budget);
    int n;
    n = 0;
    while (valid_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("wait_y_valid", longint'(valid_cnt >= target), 1);
  endtask

  // One full transaction with per-cycle address, busy and latency checks.
  task automatic run_one(input longint exp_y);
    exp_q.push_back(AW'(exp_y));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("busy_acc", longint'(bus.busy), 1);
      check("fifo_r_address", longint'(bus.fifo_r_address), i);
      tick();
    end
    check("y_valid_latency", longint'(bus.y_valid), 1);
    check("busy_done", longint'(bus.busy), 0);
    tick();
    check("y_valid_fall", longint'(bus.y_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    bus.start = 1'b0;
    bus.coef_flat = '0;
    set_taps(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_y", longint'($signed(bus.y)), 0);
    check("reset_y_valid", longint'(bus.y_valid), 0);
    check("reset_busy", longint'(bus.busy), 0);
    check("reset_addr", longint'(bus.fifo_r_address), 0);

    // Nominal: 40*1 + 30*2 + 20*3 + 10*4
    set_taps(40, 30, 20, 10);
    set_coefs(1, 2, 3, 4);
    run_one(200);

    // Mixed signs: -5*3 + 7*-2 + 100*5 + -300*-1
    set_taps(-5, 7, 100, -300);
    set_coefs(3, -2, 5, -1);
    run_one(771);

    // Extremes: 4 * (-2048 * -128) and 4 * (-2048 * 127)
    set_taps(-2048, -2048, -2048, -2048);
    set_coefs(-128, -128, -128, -128);
`ifdef FIR4_SAT_EN
    run_one(2047);
`else
    run_one(1048576);
`endif
    set_coefs(127, 127, 127, 127);
`ifdef FIR4_SAT_EN
    run_one(-2048);
`else
    run_one(-1040384);
`endif

    // Start re-pulsed during ACC is ignored
    set_taps(40, 30, 20, 10);
    set_coefs(1, 2, 3, 4);
    v0 = valid_cnt;
    exp_q.push_back(AW'(200));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    check("start_in_acc_valids", valid_cnt - v0, 1);

    // Start held: accepted at E0, E5, E10
    v0 = valid_cnt;
    repeat (3) exp_q.push_back(AW'(200));
    bus.start = 1'b1;
    repeat (11) tick();
    bus.start = 1'b0;
    wait_valids(v0 + 3, 20);
    if (valid_cyc.size() >= v0 + 3) begin
      check("held_period_1", valid_cyc[v0+1] - valid_cyc[v0], 5);
      check("held_period_2", valid_cyc[v0+2] - valid_cyc[v0+1], 5);
    end
    repeat (6) tick();
    check("held_result_count", valid_cnt - v0, 3);

    // Coefficient change mid-ACC does not disturb the result
    v0 = valid_cnt;
    exp_q.push_back(AW'(200));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    set_coefs(-7, 9, -11, 13);
    tick();
    set_coefs(100, 100, 100, 100);
    wait_valids(v0 + 1, 10);
    tick();
    set_coefs(1, 2, 3, 4);

    // Reset at cnt = 2 aborts without a result
    v0 = valid_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("abort_addr_before", longint'(bus.fifo_r_address), 2);
    rst_n = 1'b0;
    #1;
    check("abort_y", longint'($signed(bus.y)), 0);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_addr", longint'(bus.fifo_r_address), 0);
    check("abort_y_valid", longint'(bus.y_valid), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("abort_no_valid", valid_cnt - v0, 0);
    check("abort_y_hold", longint'($signed(bus.y)), 0);
    run_one(200);

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
